reg_writeback_ctrl: RTL and testbench

- Write-side controller for the 8 x 10-bit register file. It arbitrates single-cycle ALU results and multi-cycle data-memory load responses onto the single register-file write port.
- It drives write_reg, write_data and reg_write_en through registered outputs.
- It keeps a pending-write scoreboard so the decode stage can detect RAW hazards on s0..sp.
- It sits between execute/memory and the register file.

---
 rtl/reg_writeback_ctrl_pkg.sv | 30 +++
 rtl/reg_writeback_ctrl_wb_load_queue.sv | 69 ++++++
 rtl/reg_writeback_ctrl.sv | 175 +++++++++++++++++
 tb/tb_reg_writeback_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file write-back controller:
// data/index widths, architectural register names and the write request record.
package reg_writeback_ctrl_pkg;

    localparam int DATA_W   = 10;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [ADDR_W-1:0] REG_S0 = 3'd0;
    localparam logic [ADDR_W-1:0] REG_S1 = 3'd1;
    localparam logic [ADDR_W-1:0] REG_S2 = 3'd2;
    localparam logic [ADDR_W-1:0] REG_S3 = 3'd3;
    localparam logic [ADDR_W-1:0] REG_T0 = 3'd4;
    localparam logic [ADDR_W-1:0] REG_T1 = 3'd5;
    localparam logic [ADDR_W-1:0] REG_RA = 3'd6;
    localparam logic [ADDR_W-1:0] REG_SP = 3'd7;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_LQ   = 2'd2,
        SRC_BYP  = 2'd3
    } wb_src_e;

endpackage

// File: rtl/reg_writeback_ctrl_wb_load_queue.sv
// Synchronous FIFO of pending load write-backs; push and pop may occur in the
// same cycle. Pushes when full and pops when empty are ignored.
module wb_load_queue
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  wb_req_t          push_req,
    input  logic             pop,
    output wb_req_t          head,
    output logic [CNT_W-1:0] count
);

    wb_req_t          mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push && (count_r != CNT_W'(DEPTH));
    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage, cleared on reset so stale loads never reappear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_req;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file write-back arbiter (ALU vs. queued loads) with starvation stall
// and pending-write scoreboard. Optional load bypass: WB_LD_BYPASS_EN.
module reg_writeback_ctrl
    import reg_writeback_ctrl_pkg::*;
#(
    parameter int LQ_DEPTH   = 2,
    parameter int STARVE_MAX = 4,
    localparam int CNT_W = $clog2(LQ_DEPTH) + 1,
    localparam int ST_W  = $clog2(STARVE_MAX + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_reg,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_W-1:0]   ld_reg,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_reg,
    output logic                alu_stall,
    output logic [NUM_REGS-1:0] pend_mask,
    output logic                wb_en,
    output logic [ADDR_W-1:0]   wb_reg,
    output logic [DATA_W-1:0]   wb_data,
    output logic [CNT_W-1:0]    lq_count,
    output logic                proto_err
);

    wb_req_t             lq_head_s;
    logic [CNT_W-1:0]    lq_count_s;
    logic                lq_empty_s;
    logic                lq_push_s;
    logic                lq_pop_s;
    logic                ld_xfer_s;
    wb_src_e             src_s;
    logic                sel_en_s;
    logic [ADDR_W-1:0]   sel_reg_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [ST_W-1:0]     starve_nxt_s;
    logic [NUM_REGS-1:0] pend_nxt_s;

    logic [ST_W-1:0]     starve_cnt_r;
    logic [NUM_REGS-1:0] pend_mask_r;
    logic                wb_en_r;
    logic [ADDR_W-1:0]   wb_reg_r;
    logic [DATA_W-1:0]   wb_data_r;
    logic                proto_err_r;

    wb_load_queue #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk      (clk),
        .reset    (reset),
        .push     (lq_push_s),
        .push_req ('{idx: ld_reg, data: ld_data}),
        .pop      (lq_pop_s),
        .head     (lq_head_s),
        .count    (lq_count_s)
    );

    // Readiness and stall come only from registered state, never from this cycle's dequeue.
    assign lq_empty_s = (lq_count_s == {CNT_W{1'b0}});
    assign ld_ready   = (lq_count_s < CNT_W'(LQ_DEPTH));
    assign ld_xfer_s  = ld_valid && ld_ready;
    assign alu_stall  = (starve_cnt_r == ST_W'(STARVE_MAX));

    // Source selection: ALU first, then queue head, then (optionally) a direct load.
    always_comb begin
        src_s = SRC_NONE;
        if (alu_valid) begin
            src_s = SRC_ALU;
        end else if (!lq_empty_s) begin
            src_s = SRC_LQ;
        end else begin
`ifdef WB_LD_BYPASS_EN
            if (ld_xfer_s) begin
                src_s = SRC_BYP;
            end else begin
                src_s = SRC_NONE;
            end
`else
            src_s = SRC_NONE;
`endif
        end
    end

    // Write-port mux and queue control for the selected source.
    always_comb begin
        sel_en_s   = 1'b0;
        sel_reg_s  = wb_reg_r;
        sel_data_s = wb_data_r;
        lq_pop_s   = 1'b0;
        lq_push_s  = ld_xfer_s;
        case (src_s)
            SRC_ALU: begin
                sel_en_s   = 1'b1;
                sel_reg_s  = alu_reg;
                sel_data_s = alu_data;
            end
            SRC_LQ: begin
                sel_en_s   = 1'b1;
                sel_reg_s  = lq_head_s.idx;
                sel_data_s = lq_head_s.data;
                lq_pop_s   = 1'b1;
            end
            SRC_BYP: begin
                sel_en_s   = 1'b1;
                sel_reg_s  = ld_reg;
                sel_data_s = ld_data;
                lq_push_s  = 1'b0;
            end
            SRC_NONE: begin
                sel_en_s   = 1'b0;
            end
            default: begin
                sel_en_s   = 1'b0;
            end
        endcase
    end

    // Starvation counter saturates so a protocol violation keeps the stall asserted.
    always_comb begin
        starve_nxt_s = {ST_W{1'b0}};
        if (alu_valid && !lq_empty_s) begin
            if (starve_cnt_r == ST_W'(STARVE_MAX)) begin
                starve_nxt_s = starve_cnt_r;
            end else begin
                starve_nxt_s = starve_cnt_r + {{(ST_W-1){1'b0}}, 1'b1};
            end
        end else begin
            starve_nxt_s = {ST_W{1'b0}};
        end
    end

    // Scoreboard update: a new issue to r outranks a write-back to r on the same edge.
    always_comb begin
        pend_nxt_s = pend_mask_r;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (iss_valid && (iss_reg == ADDR_W'(r))) begin
                pend_nxt_s[r] = 1'b1;
            end else if (sel_en_s && (sel_reg_s == ADDR_W'(r))) begin
                pend_nxt_s[r] = 1'b0;
            end else begin
                pend_nxt_s[r] = pend_mask_r[r];
            end
        end
    end

    // Registered write port, scoreboard, starvation state and sticky error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_en_r      <= 1'b0;
            wb_reg_r     <= {ADDR_W{1'b0}};
            wb_data_r    <= {DATA_W{1'b0}};
            pend_mask_r  <= {NUM_REGS{1'b0}};
            starve_cnt_r <= {ST_W{1'b0}};
            proto_err_r  <= 1'b0;
        end else begin
            wb_en_r      <= sel_en_s;
            wb_reg_r     <= sel_reg_s;
            wb_data_r    <= sel_data_s;
            pend_mask_r  <= pend_nxt_s;
            starve_cnt_r <= starve_nxt_s;
            proto_err_r  <= proto_err_r | (alu_valid & alu_stall);
        end
    end

    assign wb_en     = wb_en_r;
    assign wb_reg    = wb_reg_r;
    assign wb_data   = wb_data_r;
    assign pend_mask = pend_mask_r;
    assign lq_count  = lq_count_s;
    assign proto_err = proto_err_r;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios then random
// traffic, all compared against a transaction-level model kept in the bench.
module tb_reg_writeback_ctrl;

    localparam int LQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [2:0] alu_reg;
    logic [9:0] alu_data;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_reg;
    logic [9:0] ld_data;
    logic       iss_valid;
    logic [2:0] iss_reg;
    logic       alu_stall;
    logic [7:0] pend_mask;
    logic       wb_en;
    logic [2:0] wb_reg;
    logic [9:0] wb_data;
    logic [1:0] lq_count;
    logic       proto_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit [2:0] r;
        bit [9:0] d;
    } ent_t;

    ent_t     m_q[$];
    int       m_starve;
    bit [7:0] m_pend;
    bit       m_en;
    bit [2:0] m_reg;
    bit [9:0] m_data;
    bit       m_perr;

    reg_writeback_ctrl #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_reg(ld_reg), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_reg(iss_reg), .alu_stall(alu_stall),
        .pend_mask(pend_mask), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .lq_count(lq_count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_starve = 0;
        m_pend   = 8'h00;
        m_en     = 1'b0;
        m_reg    = 3'd0;
        m_data   = 10'd0;
        m_perr   = 1'b0;
    endtask

    // Advance the model by one clock according to the write-back rules.
    task automatic model_step();
        bit   ready;
        bit   stall;
        bit   xfer;
        bit   nonempty;
        bit   used;
        ent_t e;
        if (!reset) begin
            model_reset();
        end else begin
            ready    = (m_q.size() < LQ_DEPTH);
            stall    = (m_starve == STARVE_MAX);
            xfer     = ld_valid && ready;
            nonempty = (m_q.size() > 0);
            used     = 1'b0;
            if (alu_valid) begin
                m_en = 1'b1; m_reg = alu_reg; m_data = alu_data;
                m_starve = nonempty ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                if (stall) m_perr = 1'b1;
            end else if (nonempty) begin
                e = m_q.pop_front();
                m_en = 1'b1; m_reg = e.r; m_data = e.d;
                m_starve = 0;
`ifdef WB_LD_BYPASS_EN
            end else if (xfer) begin
                m_en = 1'b1; m_reg = ld_reg; m_data = ld_data;
                used = 1'b1;
                m_starve = 0;
`endif
            end else begin
                m_en = 1'b0;
                m_starve = 0;
            end
            if (xfer && !used) begin
                e.r = ld_reg; e.d = ld_data;
                m_q.push_back(e);
            end
            if (m_en) m_pend[m_reg] = 1'b0;
            if (iss_valid) m_pend[iss_reg] = 1'b1;
        end
    endtask

    // One clock: check handshake outputs before the edge, registered outputs after it.
    task automatic tick();
        chk("ld_ready", ld_ready, (m_q.size() < LQ_DEPTH) ? 1 : 0);
        chk("alu_stall", alu_stall, (m_starve == STARVE_MAX) ? 1 : 0);
        model_step();
        @(posedge clk);
        #1;
        chk("wb_en", wb_en, m_en);
        if (m_en) begin
            chk("wb_reg", wb_reg, m_reg);
            chk("wb_data", wb_data, m_data);
        end
        chk("pend_mask", pend_mask, m_pend);
        chk("lq_count", lq_count, m_q.size());
        chk("proto_err", proto_err, m_perr);
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_reg = 3'd0; alu_data = 10'd0;
        ld_valid = 1'b0; ld_reg = 3'd0; ld_data = 10'd0;
        iss_valid = 1'b0; iss_reg = 3'd0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with traffic present: nothing is accepted or written.
        alu_valid = 1'b1; alu_reg = 3'd5; alu_data = 10'h155;
        ld_valid = 1'b1; ld_reg = 3'd2; ld_data = 10'h0AA;
        iss_valid = 1'b1; iss_reg = 3'd3;
        repeat (3) tick();
        chk("rst_wb_en", wb_en, 0);
        chk("rst_lq_count", lq_count, 0);
        chk("rst_ld_ready", ld_ready, 1);
        idle_inputs();
        reset = 1'b1;
        tick();

        // ALU path with pending-bit clear.
        iss_valid = 1'b1; iss_reg = 3'd4;
        tick();
        chk("pend4_set", pend_mask[4], 1);
        iss_valid = 1'b0;
        alu_valid = 1'b1; alu_reg = 3'd4; alu_data = 10'h2A5;
        tick();
        chk("alu_wb_reg", wb_reg, 4);
        chk("alu_wb_data", wb_data, 10'h2A5);
        chk("pend4_clr", pend_mask[4], 0);

        // Two loads queued behind ALU traffic, then drained in order.
        alu_reg = 3'd0; alu_data = 10'h001;
        ld_valid = 1'b1; ld_reg = 3'd1; ld_data = 10'h011;
        tick();
        ld_reg = 3'd2; ld_data = 10'h022;
        tick();
        ld_valid = 1'b0;
        chk("lq_full_ready", ld_ready, 0);
        chk("lq_full_count", lq_count, 2);
        alu_valid = 1'b0;
        tick();
        chk("drain1_reg", wb_reg, 1);
        chk("drain1_data", wb_data, 10'h011);
        tick();
        chk("drain2_reg", wb_reg, 2);
        chk("drain2_data", wb_data, 10'h022);
        tick();

        // Starvation: ALU yields when stalled.
        alu_valid = 1'b1; alu_reg = 3'd0; alu_data = 10'h100;
        ld_valid = 1'b1; ld_reg = 3'd5; ld_data = 10'h155;
        tick();
        ld_valid = 1'b0;
        repeat (STARVE_MAX) tick();
        chk("starve_stall", alu_stall, 1);
        alu_valid = 1'b0;
        tick();
        chk("starve_drain_reg", wb_reg, 5);
        chk("starve_drain_data", wb_data, 10'h155);
        chk("starve_release", alu_stall, 0);

        // Starvation ignored by upstream: sticky protocol error.
        alu_valid = 1'b1;
        ld_valid = 1'b1; ld_reg = 3'd7; ld_data = 10'h177;
        tick();
        ld_valid = 1'b0;
        repeat (STARVE_MAX + 1) tick();
        chk("proto_err_set", proto_err, 1);
        chk("starve_saturated", alu_stall, 1);
        alu_valid = 1'b0;
        repeat (2) tick();
        chk("proto_err_sticky", proto_err, 1);

        // Issue and write-back to the same register on one edge.
        iss_valid = 1'b1; iss_reg = 3'd6;
        tick();
        alu_valid = 1'b1; alu_reg = 3'd6; alu_data = 10'h066;
        tick();
        chk("collide_pend6", pend_mask[6], 1);
        idle_inputs();
        tick();

        // Load into an empty queue with no ALU traffic.
        ld_valid = 1'b1; ld_reg = 3'd3; ld_data = 10'h3FF;
        tick();
        ld_valid = 1'b0;
`ifdef WB_LD_BYPASS_EN
        chk("byp_wb_en", wb_en, 1);
        chk("byp_wb_data", wb_data, 10'h3FF);
`else
        chk("nobyp_wb_en", wb_en, 0);
        chk("nobyp_count", lq_count, 1);
`endif
        tick();
        chk("ld_lat2_wb_en", wb_en, 0 + (m_en ? 1 : 0));
        chk("ld_lat2_count", lq_count, 0);

        // Mid-operation reset discards queued loads.
        alu_valid = 1'b1;
        ld_valid = 1'b1; ld_reg = 3'd1; ld_data = 10'h201;
        tick();
        reset = 1'b0;
        idle_inputs();
        tick();
        chk("midrst_count", lq_count, 0);
        reset = 1'b1;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 63) != 0);
            alu_valid = (m_starve == STARVE_MAX) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            alu_reg   = 3'($urandom);
            alu_data  = 10'($urandom);
            ld_valid  = ($urandom_range(0, 1) == 1);
            ld_reg    = 3'($urandom);
            ld_data   = 10'($urandom);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_reg   = 3'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
